// File: rtl/data_ram_ws.sv
// Data-RAM responder with configurable wait states and byte-lane writes.
// Holds the pipeline through stallreq_o until the access is acknowledged.
module data_ram_ws #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic ZERO_WS = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    l_we;
  logic [ADDR_WIDTH-1:0]   l_idx;
  logic [3:0]              l_sel;
  logic [31:0]             l_data;
  logic [31:0]             mem [DEPTH];

  logic                    c_go;
  logic                    c_we;
  logic [ADDR_WIDTH-1:0]   c_idx;
  logic [3:0]              c_sel;
  logic [31:0]             c_data;

  logic unused_addr;
  assign unused_addr = ^{addr_i[1:0], addr_i[31:ADDR_WIDTH+2]};

  assign stallreq_o = rst & ce_i & (state != S_ACK);
  assign busy_o     = (state != S_IDLE);

  // Zero-wait commits straight from the live inputs on the IDLE edge.
  always_comb begin
    c_go   = 1'b0;
    c_we   = l_we;
    c_idx  = l_idx;
    c_sel  = l_sel;
    c_data = l_data;
    if (state == S_IDLE) begin
      c_we   = we_i;
      c_idx  = addr_i[ADDR_WIDTH+1:2];
      c_sel  = sel_i;
      c_data = data_i;
      c_go   = rst & ce_i & ZERO_WS;
    end else begin
      c_go   = rst & ce_i & (state == S_WAIT) & (cnt == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (c_go && c_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      data_o <= 32'd0;
      l_we   <= 1'b0;
      l_idx  <= '0;
      l_sel  <= 4'd0;
      l_data <= 32'd0;
    end else begin
      if (c_go && !c_we) data_o <= mem[c_idx];
      unique case (state)
        S_IDLE: begin
          if (ce_i) begin
            l_we   <= we_i;
            l_idx  <= addr_i[ADDR_WIDTH+1:2];
            l_sel  <= sel_i;
            l_data <= data_i;
            if (ZERO_WS) begin
              state <= S_ACK;
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!ce_i)            state <= S_IDLE;
          else if (cnt == 4'd0) state <= S_ACK;
          else                  cnt   <= cnt - 4'd1;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_ram_ws.md
Name: data_ram_ws

Overview:
- Data-memory responder on the CPU's data-RAM port: serves ram_ce/ram_we/ram_sel/ram_addr/ram_data requests from the MEM stage and returns ram_data_i.
- Models a slow memory with a configurable number of wait states.
- Holds the pipeline through the existing ctrl stall mechanism, via a stall request.
- Word-organised array with byte-lane writes; the MEM stage performs read-data byte/halfword extraction.

Parameters:
- ADDR_WIDTH, 10, log2 of depth in 32-bit words (1024 words).
- WAIT_CYCLES, 2, extra wait cycles per access; legal 0..15.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- ce_i  input  1  access request, held stable by the CPU while stallreq_o=1
- we_i  input  1  1=write, 0=read
- addr_i  input  32  byte address; word index = addr_i[ADDR_WIDTH+1:2]; bits [1:0] and above ADDR_WIDTH+1 ignored (wrap)
- sel_i  input  4  byte enables: sel_i[3]->[31:24], [2]->[23:16], [1]->[15:8], [0]->[7:0]
- data_i  input  32  write data
- data_o  output  32  read data, registered
- stallreq_o  output  1  pipeline stall request to ctrl
- busy_o  output  1  1 when state != IDLE

Behaviour:
- FSM states: IDLE, WAIT, ACK. 4-bit wait counter cnt.
- Reset (rst=0, async):
  - state=IDLE, cnt=0, data_o=0, stallreq_o=0, busy_o=0.
  - The memory array is not reset and its contents are undefined.
- stallreq_o = ce_i & (state != ACK), combinational. It is asserted in the same cycle a request appears.
- IDLE:
  - If ce_i=1: latch we/word index/sel/data.
    - WAIT_CYCLES=0: go to ACK, and commit the access on that edge.
    - Otherwise: cnt=WAIT_CYCLES-1, go to WAIT.
  - If ce_i=0: stay in IDLE.
- WAIT:
  - If ce_i=0 (flush): abort; go to IDLE with no array write and data_o unchanged.
  - Else if cnt=0: commit the access, go to ACK.
  - Else: cnt-1.
- Commit:
  - Write: each lane with sel=1 is updated from the latched data; lanes with sel=0 keep their value; data_o is unchanged.
  - Read: data_o <= full array word; sel is ignored for reads.
- ACK:
  - stallreq_o=0, and data_o is valid for this cycle; the CPU advances at the end of the cycle.
  - Next edge: go to IDLE unconditionally.
- Latency: stallreq_o is high for WAIT_CYCLES+1 cycles; total access time is WAIT_CYCLES+2 cycles including ACK.
- Back-to-back: a request present in the cycle after ACK starts a new access from IDLE. No pipelining of requests.
- Reads use latched inputs only. Changes on addr/sel/data/we after IDLE latching are ignored until the next IDLE.
- sel_i=0000 write: the full handshake occurs and no lanes change.
- Reset mid-access: immediate return to IDLE. An uncommitted write is lost; an already-committed write is kept.

Test Plan:
- Reset: rst=0 mid-WAIT -> state IDLE, data_o=0, stallreq_o=0 immediately (async), no write committed.
- Word write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF at addr 0x10, sel=1111 -> stallreq_o high exactly 3 cycles, then ACK.
  - Read of 0x10 -> data_o=0xDEADBEEF in ACK cycle, after 3 stall cycles.
- Byte lanes: preload 0x11223344 at 0x20; write data 0xAABBCCDD with sel=1000, then sel=0001 -> read returns 0xAA2233DD.
- Flush abort: start write 0x55 to 0x30 (old 0x0), drop ce_i during WAIT -> back to IDLE; later read of 0x30 returns 0x00000000.
- Wrap and zero wait:
  - WAIT_CYCLES=0, ADDR_WIDTH=10: write 0x12345678 at addr 0x1000 -> stall 1 cycle.
  - Read addr 0x0000 -> 0x12345678 (index wraps).
- Back-to-back: two consecutive reads of 0x40/0x44 holding ce_i -> ACK, one IDLE cycle with stallreq_o=1, then the second access; each returns the correct word; busy_o=0 only in IDLE.
